// File: rtl/rc_emu_pkg.sv
// Shared constants, FSM state type and saturation helper for the RC low-pass stepper.
package rc_emu_pkg;

   localparam int DEF_WIDTH      = 18;
   localparam int DEF_FRAC       = 14;
   localparam int DEF_ALPHA_W    = 16;
   localparam int DEF_ALPHA      = 6237;
   localparam int DEF_SETTLE_CNT = 4;
   localparam int ONE            = 1 << DEF_FRAC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_MUL  = 2'd2,
      ST_ACC  = 2'd3
   } state_t;

   // Clamp a signed value into the two's-complement range of 'width' bits.
   function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] val,
                                                       input int                 width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (val > hi) begin
         return hi;
      end else if (val < lo) begin
         return lo;
      end else begin
         return val;
      end
   endfunction

endpackage

// File: rtl/fx_mul_round.sv
// Signed x unsigned-fraction multiply with round-half-up arithmetic shift by AW bits.
module fx_mul_round
   import rc_emu_pkg::*;
#(
   parameter int DW = DEF_WIDTH + 1,
   parameter int AW = DEF_ALPHA_W
)(
   input  logic signed [DW-1:0] i_a,
   input  logic        [AW-1:0] i_b,
   output logic signed [DW-1:0] o_p
);

   localparam int PW = DW + AW + 1;
   localparam logic signed [PW-1:0] HALF = PW'(1'b1) <<< (AW - 1);

   logic signed [PW-1:0] w_a_ext;
   logic signed [PW-1:0] w_b_ext;
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_rnd;

   assign w_a_ext = {{(AW + 1){i_a[DW-1]}}, i_a};
   assign w_b_ext = {{(DW + 1){1'b0}}, i_b};
   assign w_prod  = w_a_ext * w_b_ext;
   assign w_rnd   = w_prod + HALF;
   // |alpha| < 1 keeps the shifted result inside DW bits, so the cast never loses magnitude.
   assign o_p     = DW'(w_rnd >>> AW);

endmodule

// File: rtl/rc_lpf_stepper.sv
// First-order RC low-pass stepper: each accepted request applies v_out += alpha*(v_in - v_out).
module rc_lpf_stepper
   import rc_emu_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FRAC       = DEF_FRAC,
   parameter int ALPHA_W    = DEF_ALPHA_W,
   parameter int ALPHA      = DEF_ALPHA,
   parameter int SETTLE_TOL = 1 << (FRAC - 10),
   parameter int SETTLE_CNT = DEF_SETTLE_CNT
)(
   input  logic                    emu_clk,
   input  logic                    emu_rst_n,
   input  logic                    clr,
   input  logic signed [WIDTH-1:0] v_in,
   input  logic                    step_req,
   output logic                    step_ack,
   output logic                    busy,
   output logic signed [WIDTH-1:0] v_out,
   output logic                    settled
);

   localparam int                 CNT_W   = $clog2(SETTLE_CNT + 1);
   localparam logic [ALPHA_W-1:0] ALPHA_Q = ALPHA_W'(ALPHA);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SETTLE_CNT);
   localparam logic [WIDTH+1:0]   TOL_Q   = (WIDTH + 2)'(SETTLE_TOL);

   state_t                  r_state;
   logic signed [WIDTH:0]   r_diff_cap;
   logic signed [WIDTH:0]   r_diff;
   logic signed [WIDTH-1:0] r_vin_cap;
   logic signed [WIDTH-1:0] r_v_out;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_ack;
   logic                    r_busy;
   logic                    r_settled;

   logic signed [WIDTH:0]   w_diff_new;
   logic signed [WIDTH:0]   w_prod;
   logic signed [WIDTH+1:0] w_sum;
   logic signed [WIDTH-1:0] w_v_new;
   logic signed [WIDTH+1:0] w_err;
   logic [WIDTH+1:0]        w_abs_err;
   logic                    w_in_tol;
   logic [CNT_W-1:0]        w_cnt_next;

   // One extra bit so v_in - v_out can never overflow.
   assign w_diff_new = {v_in[WIDTH-1], v_in} - {r_v_out[WIDTH-1], r_v_out};

   fx_mul_round #(
      .DW (WIDTH + 1),
      .AW (ALPHA_W)
   ) u_mul (
      .i_a (r_diff),
      .i_b (ALPHA_Q),
      .o_p (w_prod)
   );

   // Saturating accumulate and settle-tolerance evaluation on the would-be new output.
   always_comb begin
      w_sum     = {{2{r_v_out[WIDTH-1]}}, r_v_out} + {w_prod[WIDTH], w_prod};
      w_v_new   = WIDTH'(sat_to_width(32'(w_sum), WIDTH));
      w_err     = {{2{r_vin_cap[WIDTH-1]}}, r_vin_cap} - {{2{w_v_new[WIDTH-1]}}, w_v_new};
      w_abs_err = w_err;
      if (w_err[WIDTH+1]) begin
         w_abs_err = ~w_err + (WIDTH + 2)'(1'b1);
      end else begin
         w_abs_err = w_err;
      end
      w_in_tol   = (w_abs_err <= TOL_Q);
      w_cnt_next = {CNT_W{1'b0}};
      if (!w_in_tol) begin
         w_cnt_next = {CNT_W{1'b0}};
      end else if (r_cnt == CNT_MAX) begin
         w_cnt_next = r_cnt;
      end else begin
         w_cnt_next = r_cnt + CNT_W'(1'b1);
      end
   end

   // Step sequencer; results commit on entry to ACC so ack and new v_out appear together.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         r_state    <= ST_IDLE;
         r_diff_cap <= {(WIDTH + 1){1'b0}};
         r_diff     <= {(WIDTH + 1){1'b0}};
         r_vin_cap  <= {WIDTH{1'b0}};
         r_v_out    <= {WIDTH{1'b0}};
         r_cnt      <= {CNT_W{1'b0}};
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
         r_settled  <= 1'b0;
      end else if (clr) begin
         r_state   <= ST_IDLE;
         r_v_out   <= {WIDTH{1'b0}};
         r_cnt     <= {CNT_W{1'b0}};
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
         r_settled <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= 1'b0;
               if (step_req) begin
                  r_diff_cap <= w_diff_new;
                  r_vin_cap  <= v_in;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SUB;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SUB: begin
               r_diff  <= r_diff_cap;
               r_state <= ST_MUL;
            end
            ST_MUL: begin
               r_v_out   <= w_v_new;
               r_cnt     <= w_cnt_next;
               r_settled <= (w_cnt_next == CNT_MAX);
               r_ack     <= 1'b1;
               r_state   <= ST_ACC;
            end
            ST_ACC: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign step_ack = r_ack;
   assign busy     = r_busy;
   assign v_out    = r_v_out;
   assign settled  = r_settled;

endmodule

// File: tb/tb_rc_lpf_stepper.sv
// Directed self-checking bench for rc_lpf_stepper with an integer reference of the filter step.
module tb_rc_lpf_stepper;
   import rc_emu_pkg::*;

   logic               emu_clk = 1'b0;
   logic               emu_rst_n;
   logic               clr;
   logic signed [17:0] v_in;
   logic               step_req;
   logic               step_ack;
   logic               busy;
   logic signed [17:0] v_out;
   logic               settled;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_v;
   int   m_cnt;
   logic m_set;

   rc_lpf_stepper dut (
      .emu_clk   (emu_clk),
      .emu_rst_n (emu_rst_n),
      .clr       (clr),
      .v_in      (v_in),
      .step_req  (step_req),
      .step_ack  (step_ack),
      .busy      (busy),
      .v_out     (v_out),
      .settled   (settled)
   );

   always #5 emu_clk = ~emu_clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      m_v   = 0;
      m_cnt = 0;
      m_set = 1'b0;
   endfunction

   // v += floor((v_in - v)*6237/65536 + 1/2), clamped to 18-bit signed; then settle counter.
   function automatic void model_step(input int vin);
      longint d, p, s, e;
      d = longint'(vin) - longint'(m_v);
      p = (d * 64'sd6237 + 64'sd32768) >>> 16;
      s = longint'(m_v) + p;
      if (s > 64'sd131071) s = 64'sd131071;
      else if (s < -64'sd131072) s = -64'sd131072;
      m_v = int'(s);
      e = longint'(vin) - s;
      if (e < 0) e = -e;
      if (e <= 16) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      else m_cnt = 0;
      m_set = (m_cnt == 4);
   endfunction

   task automatic run_step(input int vin, input string tag);
      int cyc;
      v_in     = 18'(vin);
      step_req = 1'b1;
      @(negedge emu_clk);
      step_req = 1'b0;
      v_in     = ~v_in;
      cyc      = 1;
      while (step_ack !== 1'b1 && cyc < 12) begin
         @(negedge emu_clk);
         cyc++;
      end
      model_step(vin);
      check({tag, "_latency"}, cyc, 3);
      check({tag, "_vout"}, v_out, m_v);
      check({tag, "_settled"}, settled, m_set);
      @(negedge emu_clk);
      check({tag, "_ack_pulse"}, step_ack, 0);
   endtask

   task automatic run_burst(input int vin, input int n, input string tag);
      int t, acks, last, prev;
      v_in     = 18'(vin);
      step_req = 1'b1;
      t = 0; acks = 0; last = 0; prev = v_out;
      while (acks < n && t < 4 * n + 12) begin
         @(negedge emu_clk);
         t++;
         if (step_ack === 1'b1) begin
            check({tag, "_ack_gap"}, t - last, (acks == 0) ? 3 : 4);
            last = t;
            acks++;
            model_step(vin);
            check({tag, "_vout"}, v_out, m_v);
            check({tag, "_settled"}, settled, m_set);
            check({tag, "_no_wrap"}, (vin >= prev) ? (v_out >= prev) : (v_out <= prev), 1);
            prev = v_out;
            if (acks == n) step_req = 1'b0;
         end
      end
      check({tag, "_ack_count"}, acks, n);
      step_req = 1'b0;
      @(negedge emu_clk);
   endtask

   initial begin
      int acks_seen;
      emu_rst_n = 1'b0;
      clr       = 1'b0;
      step_req  = 1'b0;
      v_in      = 18'sd0;
      model_clear();
      repeat (2) @(negedge emu_clk);
      check("rst_vout", v_out, 0);
      check("rst_ack", step_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_settled", settled, 0);
      emu_rst_n = 1'b1;
      @(negedge emu_clk);

      // Single step with cycle-by-cycle busy/ack profile.
      v_in     = 18'(ONE);
      step_req = 1'b1;
      @(negedge emu_clk);
      step_req = 1'b0;
      check("single_busy_c1", busy, 1);
      check("single_ack_c1", step_ack, 0);
      @(negedge emu_clk);
      check("single_busy_c2", busy, 1);
      check("single_ack_c2", step_ack, 0);
      @(negedge emu_clk);
      check("single_busy_c3", busy, 1);
      check("single_ack_c3", step_ack, 1);
      check("single_vout", v_out, 1559);
      model_step(16384);
      @(negedge emu_clk);
      check("single_busy_c4", busy, 0);
      check("single_ack_c4", step_ack, 0);
      check("single_vout_hold", v_out, 1559);

      clr = 1'b1;
      @(negedge emu_clk);
      clr = 1'b0;
      model_clear();
      check("clr_idle_vout", v_out, 0);
      check("clr_idle_busy", busy, 0);

      // Step response and settling from zero.
      run_burst(16384, 10, "resp10");
      check("resp10_window", (v_out >= 10340 && v_out <= 10372), 1);
      run_burst(16384, 15, "resp25");
      check("resp25_window", (v_out >= 15018 && v_out <= 15050), 1);
      run_burst(16384, 55, "settle80");
      check("settle_high", settled, 1);
      run_step(0, "drop");
      check("drop_settled_low", settled, 0);
      run_burst(16384, 70, "resettle");
      check("resettle_high", settled, 1);

      // clr while in MUL with req held; clr+req together must not start a step.
      v_in     = 18'sd0;
      step_req = 1'b1;
      @(negedge emu_clk);
      @(negedge emu_clk);
      clr = 1'b1;
      @(negedge emu_clk);
      model_clear();
      check("clrmul_ack", step_ack, 0);
      check("clrmul_vout", v_out, 0);
      check("clrmul_settled", settled, 0);
      check("clrmul_busy", busy, 0);
      @(negedge emu_clk);
      check("clrreq_not_accepted", busy, 0);
      clr      = 1'b0;
      step_req = 1'b0;
      acks_seen = 0;
      repeat (6) begin
         @(negedge emu_clk);
         if (step_ack === 1'b1) acks_seen++;
      end
      check("clrmul_no_late_ack", acks_seen, 0);

      // Drive toward both rails.
      run_burst(131071, 150, "sat_pos");
      check("sat_pos_near_max", (v_out > 131000 && v_out <= 131071), 1);
      run_burst(-131072, 150, "sat_neg");
      check("sat_neg_near_min", (v_out < -131000 && v_out >= -131072), 1);

      // Asynchronous reset while in ACC, applied between clock edges.
      v_in     = 18'(ONE);
      step_req = 1'b1;
      @(negedge emu_clk);
      step_req = 1'b0;
      @(negedge emu_clk);
      @(negedge emu_clk);
      check("arst_pre_ack", step_ack, 1);
      #2 emu_rst_n = 1'b0;
      #1;
      check("arst_vout", v_out, 0);
      check("arst_ack", step_ack, 0);
      check("arst_busy", busy, 0);
      check("arst_settled", settled, 0);
      @(negedge emu_clk);
      emu_rst_n = 1'b1;
      model_clear();
      acks_seen = 0;
      repeat (6) begin
         @(negedge emu_clk);
         if (step_ack === 1'b1) acks_seen++;
      end
      check("arst_no_ack", acks_seen, 0);
      check("arst_idle_busy", busy, 0);
      run_step(-16384, "neg");
      check("neg_vout", v_out, -1559);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
